// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the state enum used by the top-level controller.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
// One-bit combinational full-subtractor cell: diff = x - y - bin.
// Ports:
//   x    in   minuend bit
//   y    in   subtrahend bit
//   bin  in   borrow in
//   diff out  difference bit
//   bout out  borrow out (1 when x < y + bin)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor computing {bo, d} = a - b - bi over W cycles, LSB
// first, with one shared full_subtractor cell. Operands arrive on a
// valid/ready handshake; the result is presented on a valid/ready handshake
// and held until consumed. No overlap between consuming a result and
// accepting the next operand.
// Optional: define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow
// output ovf.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, bi)
//   out_valid/out_ready result handshake (d, bo[, ovf])
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bo
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;   // working result, shifted in from the MSB
  logic [W-1:0]   d_q, d_d;       // presented result, updated once per op
  logic           br_q, br_d;
  logic           bo_q, bo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic           fs_diff;
  logic           fs_bout;
  logic [W-1:0]   diff_vec;
  logic [W-1:0]   res_shift;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (br_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  // Shift the new bit in at the MSB; written with shifts so W = 1 needs no
  // special case.
  assign diff_vec  = W'(fs_diff);
  assign res_shift = (res_q >> 1) | (diff_vec << (W - 1));

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    br_d    = br_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bi;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        br_d  = fs_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // The result registers only change here, so d/bo stay put
          // through IDLE and BUSY.
          d_d     = res_shift;
          bo_d    = fs_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // On the last bit the operand LSBs are the original MSBs.
          ovf_d   = (a_q[0] ^ b_q[0]) & (a_q[0] ^ fs_diff);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the whole datapath is cleared on reset (not just the FSM) so the
  // outputs have defined values before the first operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bo        = bo_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed and exhaustive checks of serial_subtractor with W = 4.
// Define SERIAL_SUBTRACTOR_OVF_EN to also exercise the ovf output.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif
  logic         last_ovf;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: one complete operation with out_ready held high.
  // Starts and ends #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [3:0] ai, input logic [3:0] bv,
                        input logic bin, output logic [3:0] dout,
                        output logic bout, output int lat);
    a = ai; b = bv; bi = bin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = d;
    bout = bo;
    last_ovf = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    last_ovf = ovf;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (d !== 4'h0) begin errors++; $display("FAIL reset_d got=%h exp=0", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo got=%b exp=0", bo); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    logic [3:0] dr; logic br; int lat;
    run_op(4'd5, 4'd3, 1'b0, dr, br, lat);
    checks++; if (lat !== W) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
    checks++; if (dr !== 4'b0010) begin errors++; $display("FAIL basic_d got=%b exp=0010", dr); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL basic_bo got=%b exp=0", br); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [3:0] va [3] = '{4'd3, 4'd0, 4'd15};
    logic [3:0] vb [3] = '{4'd5, 4'd0, 4'd15};
    logic       vi [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] vd [3] = '{4'b1110, 4'b1111, 4'b0000};
    logic       vo [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] dr; logic br; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vi[i], dr, br, lat);
      checks++; if (dr !== vd[i]) begin errors++; $display("FAIL vector%0d_d got=%b exp=%b", i, dr, vd[i]); end
      checks++; if (br !== vo[i]) begin errors++; $display("FAIL vector%0d_bo got=%b exp=%b", i, br, vo[i]); end
    end
  endtask

  // 6 - 2 - 1 = 3, held under backpressure while in_valid pulses.
  task automatic test_backpressure();
    int lat;
    a = 4'd6; b = 4'd2; bi = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = lat[0];
      a = 4'(lat);
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== W) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, W); end
    for (int i = 0; i < 10; i++) begin
      in_valid = ~i[0];
      a = 4'(i); b = 4'(15 - i); bi = i[1];
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (d !== 4'd3) begin errors++; $display("FAIL bp_d cyc=%0d got=%h exp=3", i, d); end
      checks++; if (bo !== 1'b0) begin errors++; $display("FAIL bp_bo cyc=%0d got=%b exp=0", i, bo); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    checks++; if (d !== 4'd3) begin errors++; $display("FAIL bp_idle_hold_d got=%h exp=3", d); end
  endtask

  task automatic test_reset_midop();
    logic [3:0] dr; logic br; int lat;
    // Leave a nonzero result behind so the reset clearing is visible.
    run_op(4'd3, 4'd5, 1'b0, dr, br, lat);
    checks++; if ({br, dr} !== 5'b11110) begin errors++; $display("FAIL midop_pre got=%b exp=11110", {br, dr}); end
    a = 4'd12; b = 4'd1; bi = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;   // accepted, first BUSY cycle
    in_valid = 1'b0;
    @(posedge clk); #1;   // second BUSY cycle
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midop_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_out_valid got=%b exp=0", out_valid); end
    checks++; if (d !== 4'h0) begin errors++; $display("FAIL midop_d got=%h exp=0", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL midop_bo got=%b exp=0", bo); end
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_spurious cyc=%0d got=%b exp=0", i, out_valid); end
    end
    run_op(4'd9, 4'd4, 1'b0, dr, br, lat);
    checks++; if (dr !== 4'b0101) begin errors++; $display("FAIL midop_next_d got=%b exp=0101", dr); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL midop_next_bo got=%b exp=0", br); end
    checks++; if (lat !== W) begin errors++; $display("FAIL midop_next_latency got=%0d exp=%0d", lat, W); end
  endtask

  // All (a, b, bi) with random out_ready; results compared in order
  // against a queue of 5-bit reference differences.
  task automatic test_exhaustive();
    logic [4:0] exp_q[$];
    logic [4:0] exp_v;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic accept, consume;
    a = 4'd0; b = 4'd0; bi = 1'b0; in_valid = 1'b1;
    while (got < 512 && cyc < 20000) begin
      accept    = in_valid && in_ready;
      out_ready = 1'($urandom_range(0, 1));
      consume   = out_valid && out_ready;
      if (consume) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL exh_unexpected_result got=%b", {bo, d});
        end else begin
          exp_v = exp_q.pop_front();
          checks++;
          if ({bo, d} !== exp_v) begin
            errors++;
            $display("FAIL exh_result n=%0d got=%b exp=%b", got, {bo, d}, exp_v);
          end
        end
        got++;
      end
      if (accept) exp_q.push_back({1'b0, a} - {1'b0, b} - {4'b0, bi});
      @(posedge clk); #1;
      cyc++;
      if (accept) begin
        idx++;
        if (idx < 512) begin
          a  = 4'(idx);
          b  = 4'(idx >> 4);
          bi = idx[8];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++; if (got !== 512) begin errors++; $display("FAIL exh_count got=%0d exp=512", got); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL exh_leftover got=%0d exp=0", exp_q.size()); end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf();
    logic [3:0] dr; logic br; int lat;
    run_op(4'b0111, 4'b1111, 1'b0, dr, br, lat);
    checks++; if (dr !== 4'b1000) begin errors++; $display("FAIL ovf0_d got=%b exp=1000", dr); end
    checks++; if (last_ovf !== 1'b1) begin errors++; $display("FAIL ovf0_ovf got=%b exp=1", last_ovf); end
    run_op(4'b1000, 4'b0001, 1'b0, dr, br, lat);
    checks++; if (dr !== 4'b0111) begin errors++; $display("FAIL ovf1_d got=%b exp=0111", dr); end
    checks++; if (last_ovf !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got=%b exp=1", last_ovf); end
    run_op(4'b0100, 4'b0001, 1'b0, dr, br, lat);
    checks++; if (dr !== 4'b0011) begin errors++; $display("FAIL ovf2_d got=%b exp=0011", dr); end
    checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL ovf2_ovf got=%b exp=0", last_ovf); end
  endtask
`endif

  initial begin
    last_ovf = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_midop();
    test_exhaustive();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtractor
